// File: rtl/noc_input_port_if.sv
//==============================================================================
// Module   : noc_input_port_if
// Brief    : Upstream, arbiter and crossbar signals of one NoC router input port.
// Revision : 1.0
//==============================================================================
`default_nettype none

interface noc_input_port_if #(
    parameter int DATA_W = 32,
    parameter int AW     = 3
);
    logic              in_valid;
    logic [DATA_W+2:0] in_flit;
    logic              in_ready;
    logic              grant;
    logic              req;
    logic [2:0]        flit_id;
    logic [11:0]       length;
    logic              out_valid;
    logic [DATA_W+2:0] out_flit;
    logic              out_ready;
    logic [AW:0]       count;
    logic              err;

    modport slave (
        input  in_valid, in_flit, grant, out_ready,
        output in_ready, req, flit_id, length, out_valid, out_flit, count, err
    );

    modport master (
        output in_valid, in_flit, grant, out_ready,
        input  in_ready, req, flit_id, length, out_valid, out_flit, count, err
    );
endinterface

`default_nettype wire

// File: rtl/noc_input_port.sv
//==============================================================================
// Module   : noc_input_port
// Brief    : Flit FIFO plus framing FSM that requests the arbiter and streams packets.
// Revision : 1.0
//==============================================================================
`default_nettype none

module noc_input_port #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int AW     = 3
) (
    input  wire logic        clk,
    input  wire logic        rst,
    noc_input_port_if.slave  p
);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_XFER = 2'd2
    } state_t;

    logic [DATA_W+2:0] mem_q [DEPTH];
    logic [AW-1:0]     wp_q, rp_q;
    logic [AW:0]       count_q, count_d;
    state_t            state_q;
    logic [11:0]       len_q;
    logic              err_q;

    logic [DATA_W+2:0] head;
    logic [2:0]        hid;
    logic              empty, push, pop, ov;

    assign head  = mem_q[rp_q];
    assign hid   = head[DATA_W+2:DATA_W];
    assign empty = (count_q == '0);
    assign push  = p.in_valid && (count_q != FULL);

    // Pops come from two places: framing drops in IDLE and crossbar transfers in XFER.
    always_comb begin
        pop = 1'b0;
        ov  = 1'b0;
        case (state_q)
            S_IDLE: pop = !empty && !hid[0];
            S_XFER: begin
                ov  = p.grant && !empty;
                pop = ov && p.out_ready;
            end
            default: ;
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wp_q] <= p.in_flit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            state_q <= S_IDLE;
            len_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            err_q   <= 1'b0;
            if (push) wp_q <= wp_q + 1'b1;
            if (pop)  rp_q <= rp_q + 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (!empty) begin
                        if (hid[0]) begin
                            len_q   <= head[11:0];
                            state_q <= S_REQ;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    if (p.grant) state_q <= S_XFER;
                end
                S_XFER: begin
                    // A revoked grant parks in REQ so the packet resumes where it stopped.
                    if (pop && hid[2])  state_q <= S_IDLE;
                    else if (!p.grant)  state_q <= S_REQ;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign p.in_ready  = (count_q != FULL);
    assign p.req       = (state_q != S_IDLE);
    assign p.flit_id   = empty ? 3'b000 : hid;
    assign p.length    = len_q;
    assign p.out_valid = ov;
    assign p.out_flit  = head;
    assign p.count     = count_q;
    assign p.err       = err_q;
endmodule

`default_nettype wire

// File: tb/tb_noc_input_port.sv
//==============================================================================
// Module   : tb_noc_input_port
// Brief    : Directed and random stimulus against a queue-based model of the port.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_noc_input_port;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
    localparam int AW     = 3;
    localparam int FW     = DATA_W + 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    noc_input_port_if #(.DATA_W(DATA_W), .AW(AW)) bus ();

    noc_input_port #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .p   (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endfunction

    // Model: the port is a queue of flits plus two flags, "owns a packet" and "streaming".
    logic [FW-1:0] mq[$];
    bit            m_busy, m_xfer, m_err, armed;
    logic [11:0]   m_len;

    always @(posedge clk) begin
        int            cnt;
        logic [FW-1:0] hd;
        bit            do_pop, do_push;
        if (rst) begin
            mq.delete();
            m_busy = 0; m_xfer = 0; m_err = 0; m_len = '0; armed = 1;
        end else if (armed) begin
            cnt    = mq.size();
            hd     = (cnt > 0) ? mq[0] : '0;
            do_pop = 0;
            m_err  = 0;
            if (!m_busy) begin
                if (cnt > 0) begin
                    if (hd[DATA_W]) begin m_len = hd[11:0]; m_busy = 1; end
                    else begin do_pop = 1; m_err = 1; end
                end
            end else if (!m_xfer) begin
                if (bus.grant) m_xfer = 1;
            end else if (bus.grant && cnt > 0 && bus.out_ready) begin
                do_pop = 1;
                if (hd[DATA_W+2]) begin m_busy = 0; m_xfer = 0; end
            end else if (!bus.grant) begin
                m_xfer = 0;
            end
            do_push = bus.in_valid && (cnt < DEPTH);
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back(bus.in_flit);
        end
    end

    logic [FW-1:0] dut_out[$];

    always @(negedge clk) begin
        int            cnt;
        logic [FW-1:0] hd;
        bit            e_ov;
        if (armed) begin
            cnt  = mq.size();
            hd   = (cnt > 0) ? mq[0] : '0;
            e_ov = m_busy && m_xfer && bus.grant && (cnt > 0);
            chk("count",     64'(bus.count),    64'(cnt));
            chk("in_ready",  64'(bus.in_ready), 64'(cnt != DEPTH));
            chk("req",       64'(bus.req),      64'(m_busy));
            chk("flit_id",   64'(bus.flit_id),  (cnt > 0) ? 64'(hd[FW-1:DATA_W]) : 64'd0);
            chk("length",    64'(bus.length),   64'(m_len));
            chk("err",       64'(bus.err),      64'(m_err));
            chk("out_valid", 64'(bus.out_valid), 64'(e_ov));
            if (e_ov) chk("out_flit", 64'(bus.out_flit), 64'(hd));
            if (bus.out_valid && bus.out_ready) dut_out.push_back(bus.out_flit);
        end
    end

    logic [FW-1:0] exp_q[$];

    function automatic logic [FW-1:0] mk(input logic [2:0] id, input logic [DATA_W-1:0] pl);
        return {id, pl};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [FW-1:0] f, input bit expected);
        bus.in_valid = 1'b1;
        bus.in_flit  = f;
        if (expected) exp_q.push_back(f);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(input int n);
        int k = 0;
        while (dut_out.size() < n && k < 200) begin tick(); k++; end
        chk("wait_out_size", 64'(dut_out.size()), 64'(n));
    endtask

    task automatic cmp_out(string nm);
        int n = (dut_out.size() < exp_q.size()) ? dut_out.size() : exp_q.size();
        chk({nm, "_n"}, 64'(dut_out.size()), 64'(exp_q.size()));
        for (int i = 0; i < n; i++) chk({nm, "_flit"}, 64'(dut_out[i]), 64'(exp_q[i]));
        dut_out.delete();
        exp_q.delete();
    endtask

    task automatic send_pkt(input int n, input logic [11:0] len);
        push(mk(3'b001, {20'hABCDE, len}), 1);
        for (int i = 1; i < n - 1; i++) push(mk(3'b010, $urandom), 1);
        push(mk(3'b100, $urandom), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gap, falls, ovs;
        bit prev_req;
        bus.in_valid = 0; bus.in_flit = '0; bus.grant = 0; bus.out_ready = 1;

        // Reset
        rst = 1; tick(); tick(); rst = 0;
        chk("rst_count",    64'(bus.count),    64'd0);
        chk("rst_req",      64'(bus.req),      64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_flit_id",  64'(bus.flit_id),  64'd0);
        chk("rst_length",   64'(bus.length),   64'd0);

        // 4-flit packet with grant held
        bus.grant = 1;
        send_pkt(4, 12'd4);
        wait_out(4);
        tick();
        chk("p4_length", 64'(bus.length), 64'd4);
        chk("p4_req",    64'(bus.req),    64'd0);
        chk("p4_count",  64'(bus.count),  64'd0);
        cmp_out("p4");

        // Fill to full with no grant, then drain, then refill across the wrap
        bus.grant = 0;
        send_pkt(8, 12'd8);
        chk("full_count",    64'(bus.count),    64'd8);
        chk("full_in_ready", 64'(bus.in_ready), 64'd0);
        push(mk(3'b010, 32'hDEAD_BEEF), 0);
        chk("full_9th_count", 64'(bus.count), 64'd8);
        bus.grant = 1;
        wait_out(8);
        tick(); tick();
        cmp_out("fill");
        send_pkt(8, 12'd8);
        wait_out(8);
        tick();
        cmp_out("refill");

        // Grant revoked after 2 of 5 flits
        bus.grant = 0;
        send_pkt(5, 12'd5);
        bus.grant = 1;
        for (int k = 0; k < 50 && dut_out.size() < 2; k++) tick();
        bus.grant = 0;
        tick(); tick();
        chk("rev_req",       64'(bus.req),       64'd1);
        chk("rev_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rev_n",         64'(dut_out.size()), 64'd2);
        bus.grant = 1;
        wait_out(5);
        tick();
        cmp_out("revoke");

        // Body at the head in IDLE is dropped with an err pulse
        bus.grant = 0;
        push(mk(3'b010, 32'h1111), 0);
        chk("drop_count_pre", 64'(bus.count), 64'd1);
        tick();
        chk("drop_err",   64'(bus.err),   64'd1);
        chk("drop_count", 64'(bus.count), 64'd0);
        chk("drop_req",   64'(bus.req),   64'd0);
        tick();
        chk("drop_err_end", 64'(bus.err), 64'd0);
        push(mk(3'b101, 32'h0000_0001), 1);
        tick();
        chk("drop_hdr_req", 64'(bus.req), 64'd1);
        bus.grant = 1;
        wait_out(1);
        tick();
        cmp_out("drop");

        // Two back-to-back single-flit packets
        push(mk(3'b101, 32'h0000_0AAA), 1);
        push(mk(3'b101, 32'h0000_0BBB), 1);
        gap = 0; falls = 0; ovs = 0; prev_req = bus.req;
        for (int k = 0; k < 10; k++) begin
            if (bus.out_valid) ovs++;
            if (falls == 1 && !bus.req) gap++;
            tick();
            if (prev_req && !bus.req) falls++;
            prev_req = bus.req;
        end
        chk("b2b_falls", 64'(falls), 64'd2);
        chk("b2b_gap",   64'(gap),   64'd1);
        chk("b2b_ovs",   64'(ovs),   64'd2);
        cmp_out("b2b");

        // Random traffic with occasional grant revocation and reset
        for (int k = 0; k < 3000; k++) begin
            int r;
            logic [2:0] id;
            r = $urandom_range(0, 9);
            id = (r < 2) ? 3'b001 : (r < 7) ? 3'b010 : (r < 9) ? 3'b100 : 3'b101;
            bus.in_valid  = ($urandom_range(0, 1) == 1);
            bus.in_flit   = mk(id, $urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) bus.grant = ~bus.grant;
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 0; bus.in_valid = 0; bus.grant = 1; bus.out_ready = 1;
        for (int k = 0; k < 30; k++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire
